// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the memory bus arbiter: FSM state and transaction owner encodings.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_WAIT = 2'd2
    } arb_state_e;

    typedef enum logic {
        ARB_OWN_IF  = 1'b0,
        ARB_OWN_MEM = 1'b1
    } arb_owner_e;

    // Width of a counter that must be able to hold the value 'limit'.
    function automatic int starve_cnt_w(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between the IF/MEM requesters, the arbiter and the bus bridge.
// 'master' is the arbiter's view; 'slave' is the view of everything around it.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    localparam int MASK_W = DATA_W / 8;

    logic              if_req_valid_i;
    logic [ADDR_W-1:0] if_req_addr_i;
    logic              if_req_ready_o;
    logic              if_rsp_valid_o;
    logic [DATA_W-1:0] if_rsp_rdata_o;

    logic              mem_req_valid_i;
    logic [ADDR_W-1:0] mem_req_addr_i;
    logic              mem_req_wen_i;
    logic [DATA_W-1:0] mem_req_wdata_i;
    logic [MASK_W-1:0] mem_req_wmask_i;
    logic              mem_req_ready_o;
    logic              mem_rsp_valid_o;
    logic [DATA_W-1:0] mem_rsp_rdata_o;

    logic              bus_req_valid_o;
    logic              bus_req_ready_i;
    logic [ADDR_W-1:0] bus_req_addr_o;
    logic              bus_req_wen_o;
    logic [DATA_W-1:0] bus_req_wdata_o;
    logic [MASK_W-1:0] bus_req_wmask_o;
    logic              bus_rsp_valid_i;
    logic [DATA_W-1:0] bus_rsp_rdata_i;

    logic              ram_stall_valid_if_o;
    logic              ram_stall_valid_mem_o;

    modport master (
        input  if_req_valid_i, if_req_addr_i,
        output if_req_ready_o, if_rsp_valid_o, if_rsp_rdata_o,
        input  mem_req_valid_i, mem_req_addr_i, mem_req_wen_i, mem_req_wdata_i, mem_req_wmask_i,
        output mem_req_ready_o, mem_rsp_valid_o, mem_rsp_rdata_o,
        output bus_req_valid_o, bus_req_addr_o, bus_req_wen_o, bus_req_wdata_o, bus_req_wmask_o,
        input  bus_req_ready_i, bus_rsp_valid_i, bus_rsp_rdata_i,
        output ram_stall_valid_if_o, ram_stall_valid_mem_o
    );

    modport slave (
        output if_req_valid_i, if_req_addr_i,
        input  if_req_ready_o, if_rsp_valid_o, if_rsp_rdata_o,
        output mem_req_valid_i, mem_req_addr_i, mem_req_wen_i, mem_req_wdata_i, mem_req_wmask_i,
        input  mem_req_ready_o, mem_rsp_valid_o, mem_rsp_rdata_o,
        input  bus_req_valid_o, bus_req_addr_o, bus_req_wen_o, bus_req_wdata_o, bus_req_wmask_o,
        output bus_req_ready_i, bus_rsp_valid_i, bus_rsp_rdata_i,
        input  ram_stall_valid_if_o, ram_stall_valid_mem_o
    );

endinterface

// File: rtl/mem_bus_arbiter_prio.sv
// Winner selection between IF and MEM. MEM normally wins; with MEM_ARB_STARVE_GUARD_EN
// defined, a counter of MEM wins over a waiting IF hands IF the grant at STARVE_LIMIT.
module mem_arb_prio
    import mem_bus_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
`ifdef MEM_ARB_STARVE_GUARD_EN
    input  logic clk,
    input  logic rst_n,
`endif
    input  logic arb_en_i,
    input  logic if_valid_i,
    input  logic mem_valid_i,
    output logic grant_if_o,
    output logic grant_mem_o
);

    logic force_if;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = starve_cnt_w(STARVE_LIMIT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign force_if = if_valid_i && mem_valid_i && (cnt_q == CNT_W'(STARVE_LIMIT));

    // Only a MEM win that actually bypasses a waiting IF extends the streak.
    always_comb begin
        cnt_d = cnt_q;
        if (grant_mem_o) begin
            cnt_d = if_valid_i ? (cnt_q + CNT_W'(1)) : '0;
        end else if (grant_if_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign force_if = 1'b0;
`endif

    always_comb begin
        grant_if_o  = 1'b0;
        grant_mem_o = 1'b0;
        if (arb_en_i) begin
            if (mem_valid_i && !force_if) begin
                grant_mem_o = 1'b1;
            end else if (if_valid_i) begin
                grant_if_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Serialises single-beat IF and MEM transactions onto one memory bus port.
// Optional starvation guard for IF is enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_bus_arbiter_if.master  bus
);

    localparam int MASK_W = DATA_W / 8;

    arb_state_e        state_q, state_d;
    arb_owner_e        owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic              wen_q,   wen_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [MASK_W-1:0] wmask_q, wmask_d;

    logic arb_en;
    logic grant_if;
    logic grant_mem;
    logic rsp_fire;
    logic if_rsp_valid;
    logic mem_rsp_valid;

    // Gating with rst_n keeps the grant pulses low while reset is held.
    assign arb_en = (state_q == ARB_IDLE) && rst_n;

    mem_arb_prio #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_prio (
`ifdef MEM_ARB_STARVE_GUARD_EN
        .clk          (clk),
        .rst_n        (rst_n),
`endif
        .arb_en_i     (arb_en),
        .if_valid_i   (bus.if_req_valid_i),
        .mem_valid_i  (bus.mem_req_valid_i),
        .grant_if_o   (grant_if),
        .grant_mem_o  (grant_mem)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        wen_d   = wen_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        case (state_q)
            ARB_IDLE: begin
                if (grant_mem) begin
                    state_d = ARB_REQ;
                    owner_d = ARB_OWN_MEM;
                    addr_d  = bus.mem_req_addr_i;
                    wen_d   = bus.mem_req_wen_i;
                    wdata_d = bus.mem_req_wdata_i;
                    wmask_d = bus.mem_req_wmask_i;
                end else if (grant_if) begin
                    state_d = ARB_REQ;
                    owner_d = ARB_OWN_IF;
                    addr_d  = bus.if_req_addr_i;
                    wen_d   = 1'b0;
                    wdata_d = '0;
                    wmask_d = '0;
                end
            end
            ARB_REQ: begin
                if (bus.bus_req_ready_i) begin
                    state_d = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (bus.bus_rsp_valid_i) begin
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            owner_q <= ARB_OWN_IF;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
        end
    end

    assign bus.if_req_ready_o  = grant_if;
    assign bus.mem_req_ready_o = grant_mem;

    assign bus.bus_req_valid_o = (state_q == ARB_REQ);
    assign bus.bus_req_addr_o  = addr_q;
    assign bus.bus_req_wen_o   = wen_q;
    assign bus.bus_req_wdata_o = wdata_q;
    assign bus.bus_req_wmask_o = wmask_q;

    // Responses outside WAIT are stray and never reach a requester.
    assign rsp_fire      = (state_q == ARB_WAIT) && bus.bus_rsp_valid_i;
    assign if_rsp_valid  = rsp_fire && (owner_q == ARB_OWN_IF);
    assign mem_rsp_valid = rsp_fire && (owner_q == ARB_OWN_MEM);

    assign bus.if_rsp_valid_o  = if_rsp_valid;
    assign bus.mem_rsp_valid_o = mem_rsp_valid;
    assign bus.if_rsp_rdata_o  = if_rsp_valid  ? bus.bus_rsp_rdata_i : '0;
    assign bus.mem_rsp_rdata_o = mem_rsp_valid ? bus.bus_rsp_rdata_i : '0;

    // Stall drops in the response cycle so the pipeline advances on that edge.
    assign bus.ram_stall_valid_if_o  = bus.if_req_valid_i  && !if_rsp_valid;
    assign bus.ram_stall_valid_mem_o = bus.mem_req_valid_i && !mem_rsp_valid;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed and randomized checks of mem_bus_arbiter against a transaction-level model.
module tb_mem_bus_arbiter;

    localparam int ADDR_W       = 32;
    localparam int DATA_W       = 64;
    localparam int STARVE_LIMIT = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

    mem_bus_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    int vectors    = 0;
    int miscompares = 0;
    int txn_count  = 0;

    // stimulus
    logic        s_if_v, s_mem_v, s_mem_wen, s_ready, s_rsp_v;
    logic [31:0] s_if_addr, s_mem_addr;
    logic [63:0] s_mem_wdata, s_rdata;
    logic [7:0]  s_mem_wmask;

    // transaction-level reference model
    bit          m_busy, m_accepted, m_owner_mem, m_wen;
    logic [31:0] m_addr;
    logic [63:0] m_wdata;
    logic [7:0]  m_wmask;
    int          m_streak;
    bit          e_if_rdy, e_mem_rdy, e_bus_v, e_if_rsp, e_mem_rsp;

    // observations kept for directed checks
    logic        o_if_rdy, o_mem_rdy, o_if_rsp, o_mem_rsp, o_stall_if, o_stall_mem;
    logic [31:0] o_addr;
    logic [63:0] o_if_rdata;
    logic [7:0]  o_wmask;
    int          grant_log[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        bus_if.if_req_valid_i  = s_if_v;
        bus_if.if_req_addr_i   = s_if_addr;
        bus_if.mem_req_valid_i = s_mem_v;
        bus_if.mem_req_addr_i  = s_mem_addr;
        bus_if.mem_req_wen_i   = s_mem_wen;
        bus_if.mem_req_wdata_i = s_mem_wdata;
        bus_if.mem_req_wmask_i = s_mem_wmask;
        bus_if.bus_req_ready_i = s_ready;
        bus_if.bus_rsp_valid_i = s_rsp_v;
        bus_if.bus_rsp_rdata_i = s_rdata;
    endtask

    task automatic model_reset();
        m_busy = 0; m_accepted = 0; m_owner_mem = 0; m_streak = 0;
    endtask

    task automatic chk_reset_outputs(input string tag, input logic stall_if, input logic stall_mem);
        chk({tag, "_if_ready"},  bus_if.if_req_ready_o,  0);
        chk({tag, "_mem_ready"}, bus_if.mem_req_ready_o, 0);
        chk({tag, "_if_rsp"},    bus_if.if_rsp_valid_o,  0);
        chk({tag, "_mem_rsp"},   bus_if.mem_rsp_valid_o, 0);
        chk({tag, "_if_rdata"},  bus_if.if_rsp_rdata_o,  0);
        chk({tag, "_mem_rdata"}, bus_if.mem_rsp_rdata_o, 0);
        chk({tag, "_bus_valid"}, bus_if.bus_req_valid_o, 0);
        chk({tag, "_bus_addr"},  bus_if.bus_req_addr_o,  0);
        chk({tag, "_bus_wen"},   bus_if.bus_req_wen_o,   0);
        chk({tag, "_bus_wdata"}, bus_if.bus_req_wdata_o, 0);
        chk({tag, "_bus_wmask"}, bus_if.bus_req_wmask_o, 0);
        chk({tag, "_stall_if"},  bus_if.ram_stall_valid_if_o,  stall_if);
        chk({tag, "_stall_mem"}, bus_if.ram_stall_valid_mem_o, stall_mem);
    endtask

    // One clock cycle: called #1 after a posedge, returns #1 after the next posedge.
    task automatic step();
        drive();
        @(negedge clk);
        e_if_rdy = 0; e_mem_rdy = 0;
        if (!m_busy) begin
            if (s_mem_v && s_if_v)
                if (GUARD && m_streak >= STARVE_LIMIT) e_if_rdy = 1; else e_mem_rdy = 1;
            else if (s_mem_v) e_mem_rdy = 1;
            else if (s_if_v)  e_if_rdy = 1;
        end
        e_bus_v   = m_busy && !m_accepted;
        e_if_rsp  = m_busy && m_accepted && s_rsp_v && !m_owner_mem;
        e_mem_rsp = m_busy && m_accepted && s_rsp_v && m_owner_mem;

        o_if_rdy = bus_if.if_req_ready_o;   o_mem_rdy = bus_if.mem_req_ready_o;
        o_if_rsp = bus_if.if_rsp_valid_o;   o_mem_rsp = bus_if.mem_rsp_valid_o;
        o_stall_if = bus_if.ram_stall_valid_if_o; o_stall_mem = bus_if.ram_stall_valid_mem_o;
        o_addr = bus_if.bus_req_addr_o; o_wmask = bus_if.bus_req_wmask_o;
        o_if_rdata = bus_if.if_rsp_rdata_o;
        if (o_mem_rdy) grant_log.push_back(1); else if (o_if_rdy) grant_log.push_back(0);

        chk("if_ready",  o_if_rdy,  e_if_rdy);
        chk("mem_ready", o_mem_rdy, e_mem_rdy);
        chk("bus_valid", bus_if.bus_req_valid_o, e_bus_v);
        if (e_bus_v) begin
            chk("bus_addr", o_addr, m_addr);
            chk("bus_wen",  bus_if.bus_req_wen_o, m_wen);
            if (m_owner_mem) begin
                chk("bus_wdata", bus_if.bus_req_wdata_o, m_wdata);
                chk("bus_wmask", o_wmask, m_wmask);
            end
        end
        chk("if_rsp",   o_if_rsp,  e_if_rsp);
        chk("mem_rsp",  o_mem_rsp, e_mem_rsp);
        chk("if_rdata", o_if_rdata, e_if_rsp ? s_rdata : 64'd0);
        if (!(e_mem_rsp && m_wen))
            chk("mem_rdata", bus_if.mem_rsp_rdata_o, e_mem_rsp ? s_rdata : 64'd0);
        chk("stall_if",  o_stall_if,  s_if_v  && !e_if_rsp);
        chk("stall_mem", o_stall_mem, s_mem_v && !e_mem_rsp);

        if (e_if_rdy || e_mem_rdy) begin
            m_busy = 1; m_accepted = 0; m_owner_mem = e_mem_rdy;
            m_addr  = e_mem_rdy ? s_mem_addr : s_if_addr;
            m_wen   = e_mem_rdy && s_mem_wen;
            m_wdata = e_mem_rdy ? s_mem_wdata : 64'd0;
            m_wmask = e_mem_rdy ? s_mem_wmask : 8'd0;
            if (e_mem_rdy && s_if_v) m_streak++; else m_streak = 0;
        end else if (e_bus_v && s_ready) begin
            m_accepted = 1;
        end else if (e_if_rsp || e_mem_rsp) begin
            m_busy = 0;
            txn_count++;
            $display("txn %0d: %s %s addr=%h rdata=%h", txn_count, m_owner_mem ? "MEM" : "IF ",
                     m_wen ? "wr" : "rd", m_addr, s_rdata);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_stim();
        s_if_v = 0; s_mem_v = 0; s_mem_wen = 0; s_ready = 0; s_rsp_v = 0;
        s_if_addr = 0; s_mem_addr = 0; s_mem_wdata = 0; s_mem_wmask = 0; s_rdata = 0;
    endtask

    initial begin
        idle_stim();
        model_reset();
        rst_n = 1'b0;
        s_if_v = 1; s_mem_v = 1;
        drive();
        #3;
        chk_reset_outputs("init_rst", 1, 1);
        idle_stim();
        drive();
        @(posedge clk); #1;
        rst_n = 1'b1;
        step();

        // IF read alone: grant, address on the bus, response with data
        s_if_v = 1; s_if_addr = 32'h8000_0000; s_ready = 1;
        step();
        chk("t1_grant", o_if_rdy, 1);
        step();
        chk("t1_addr", o_addr, 32'h8000_0000);
        s_rsp_v = 1; s_rdata = 64'h1234;
        step();
        chk("t1_rsp", o_if_rsp, 1);
        chk("t1_rdata", o_if_rdata, 64'h1234);
        chk("t1_stall", o_stall_if, 0);
        idle_stim();
        step();

        // Both valid: MEM first, then IF; IF stalls until its own response
        s_if_v = 1; s_if_addr = 32'h0000_1000;
        s_mem_v = 1; s_mem_addr = 32'h0000_2000; s_ready = 1; s_rsp_v = 1; s_rdata = 64'hAA;
        step();
        chk("t2_mem_first", o_mem_rdy, 1);
        chk("t2_stall_if0", o_stall_if, 1);
        step();
        chk("t2_stall_if1", o_stall_if, 1);
        step();
        chk("t2_mem_rsp", o_mem_rsp, 1);
        chk("t2_stall_if2", o_stall_if, 1);
        s_mem_v = 0;
        step();
        chk("t2_if_second", o_if_rdy, 1);
        chk("t2_stall_if3", o_stall_if, 1);
        step();
        step();
        chk("t2_if_rsp", o_if_rsp, 1);
        idle_stim();
        step();

        // MEM write with ready held low for 3 REQ cycles
        s_mem_v = 1; s_mem_wen = 1; s_mem_addr = 32'h0000_0040;
        s_mem_wdata = 64'hDEAD_BEEF_0BAD_F00D; s_mem_wmask = 8'h0F;
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t3_wmask_hold", o_wmask, 8'h0F);
        end
        s_ready = 1;
        step();
        chk("t3_wmask_last", o_wmask, 8'h0F);
        s_ready = 0; s_rsp_v = 1;
        step();
        chk("t3_mem_rsp", o_mem_rsp, 1);
        idle_stim();
        step();
        chk("t3_single_pulse", o_mem_rsp, 0);

        // Both continuously valid with immediate bus: grant sequence
        grant_log.delete();
        s_if_v = 1; s_if_addr = 32'h0000_3000; s_mem_v = 1; s_mem_addr = 32'h0000_4000;
        s_ready = 1; s_rsp_v = 1; s_rdata = 64'h55;
        for (int i = 0; i < 30; i++) step();
        chk("t4_grants", grant_log.size(), 10);
        for (int i = 0; i < grant_log.size(); i++)
            chk($sformatf("t4_grant%0d", i), grant_log[i], (GUARD && (i % 5 == 4)) ? 0 : 1);
        idle_stim();
        step();

        // Stray response in IDLE
        s_rsp_v = 1; s_rdata = 64'hFFFF;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_no_if_rsp", o_if_rsp, 0);
            chk("t5_no_mem_rsp", o_mem_rsp, 0);
        end
        idle_stim();
        step();

        // Reset asserted while waiting for a response
        s_if_v = 1; s_if_addr = 32'h0000_5000; s_ready = 1;
        step();
        step();
        s_rsp_v = 1; s_rdata = 64'h77; s_mem_v = 1; s_mem_addr = 32'h0000_6000;
        drive();
        #1;
        chk("t6_pre_rst_rsp", bus_if.if_rsp_valid_o, 1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("t6_rst", 1, 1);
        model_reset();
        @(posedge clk); #1;
        idle_stim();
        s_rsp_v = 1; s_rdata = 64'h99;
        drive();
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("t6_late_if_rsp", o_if_rsp, 0);
            chk("t6_late_mem_rsp", o_mem_rsp, 0);
        end
        idle_stim();

        // Randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            if (!s_if_v || e_if_rsp) begin
                s_if_v = ($urandom_range(0, 2) != 0);
                s_if_addr = $urandom;
            end
            if (!s_mem_v || e_mem_rsp) begin
                s_mem_v = ($urandom_range(0, 2) != 0);
                s_mem_addr = $urandom;
                s_mem_wen = $urandom_range(0, 1);
                s_mem_wdata = {$urandom, $urandom};
                s_mem_wmask = 8'($urandom);
            end
            s_ready = $urandom_range(0, 1);
            s_rsp_v = $urandom_range(0, 1);
            s_rdata = {$urandom, $urandom};
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
